bcp_scan_ctrl: RTL and testbench
================================

Name: bcp_scan_ctrl

Overview:
- Sequencer for the bcp_check unit-clause datapath.
- On a start pulse it walks a clause memory from index 0 to NUM_CLAUSES-1 and loads each clause into the checker.
- It collects the registered unit_clause result and emits each implication (clause index, literal slot, implied value) over a valid/ready handshake.
- Sits between the clause store and the implication queue of the BCP engine.

Parameters:
- NUM_CLAUSES, 16, clauses scanned per pass (>=1).
- ADDR_W, 4, clause memory address width; $clog2(NUM_CLAUSES), minimum 1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a scan; ignored unless IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the pass completes.
- mem_rd_en  out  1  clause memory read strobe.
- mem_addr  out  ADDR_W  clause index being read.
- mem_rd_data  in  20  {clause_odd[3:0], clause_type[7:0], clause[7:0]}; valid the cycle after mem_rd_en.
- chk_clause  out  8  to checker clause.
- chk_clause_type  out  8  to checker clause_type.
- chk_clause_odd  out  4  to checker clause_odd.
- chk_unit  in  4  checker unit_clause (one-hot, registered in checker).
- impl_valid  out  1  implication available.
- impl_ready  in  1  consumer accepts.
- impl_clause  out  ADDR_W  clause index of implication.
- impl_slot  out  2  literal slot 0..3.
- impl_value  out  1  implied value = clause_type[slot].
- impl_count  out  ADDR_W+1  implications emitted this pass; cleared on start.

Behaviour:
- Reset (async, any state): state IDLE; busy, done, mem_rd_en, impl_valid = 0; mem_addr, chk_*, impl_*, impl_count = 0.
- The checker shares clk/rst.
- States: IDLE, FETCH, LOAD, EVAL, RESULT, EMIT, FINISH.
- IDLE: on start, index <= 0, impl_count <= 0, go FETCH.
- FETCH: mem_rd_en=1, mem_addr=index (registered outputs set on entry); go LOAD.
- LOAD: mem_rd_data valid; latch its three fields into the chk_* registers; go EVAL.
- EVAL: chk_* held stable; the checker registers its result at the end of this cycle; go RESULT.
- RESULT: sample chk_unit.
  - If zero: advance.
  - Else: encode slot = index of the lowest set bit, value = chk_clause_type[slot], clause = index; set impl_valid; go EMIT.
- EMIT: impl_* held stable while impl_valid && !impl_ready. On impl_valid && impl_ready: impl_valid <= 0, impl_count++, advance.
- Advance: if index == NUM_CLAUSES-1, go FINISH; else index++ and go FETCH.
- FINISH: done=1 for exactly one cycle; go IDLE. busy=0 in IDLE.
- Latency: 4 cycles per non-unit clause (FETCH..RESULT). A unit clause adds at least 1 EMIT cycle. Pass of N clauses with no implications: start to done = 4N+1 cycles.
- chk_* registers hold their last value outside LOAD. No new clause is loaded while EMIT is stalled.
- Multiple bits in chk_unit (illegal from checker): lowest slot wins, others dropped.
- start while busy: ignored; no restart.
- impl_ready high while impl_valid low: no effect.
- Reset mid-EMIT drops the pending implication.
- NUM_CLAUSES=1: a single iteration, then FINISH.
- impl_count cannot overflow (max NUM_CLAUSES; width ADDR_W+1).

Decomposition:
- Shared package bcp_pkg:
  - state enum typedef;
  - packed struct clause_word_t {odd[3:0], ctype[7:0], lits[7:0]} matching mem_rd_data;
  - constants LIT_SLOTS=4 and CLAUSE_W=20.
- One natural sub-module: bcp_onehot_enc (4-bit one-hot to 2-bit slot, lowest-set-bit priority, combinational).

Test Plan:
- Satisfied clause: mem[0]=0xC0000 (size 4, polarity 0000, lits 0), NUM_CLAUSES=1 -> no impl_valid; done 5 cycles after start; impl_count=0.
- Unit clause: mem[3]=0xEC544 (odd=1110, type=0xC5, clause=0x44), others satisfied -> exactly one impl: impl_clause=3, impl_slot=0, impl_value=1; impl_count=1.
- Back-pressure: same image, impl_ready held low 5 cycles -> impl_valid and impl_* stable for 5 cycles; mem_rd_en stays low; next FETCH only after the handshake.
- Size-2 units in clauses 1 and 2 (type 0x40, clause=0x00, odd=0001 / 0010; units from the checker are 4'b0010 / 4'b0001) -> two impls in order: (1, slot 1, value 0) then (2, slot 0, value 0); impl_count=2.
- start pulsed again mid-scan -> ignored; exactly one done pulse.
- Async rst asserted during EMIT -> impl_valid, busy, and impl_count drop to 0 immediately (no clock edge needed); next start rescans from clause 0.

Source files
------------

// File: rtl/bcp_pkg.sv
// Shared types and constants for the BCP clause-scan sequencer.
package bcp_pkg;

  localparam int unsigned LIT_SLOTS = 4;
  localparam int unsigned CLAUSE_W  = 20;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_EVAL,
    S_RESULT,
    S_EMIT,
    S_FINISH
  } scan_state_e;

  // Field layout of one clause-memory word.
  typedef struct packed {
    logic [3:0] odd;
    logic [7:0] ctype;
    logic [7:0] lits;
  } clause_word_t;

endpackage

// File: rtl/bcp_scan_ctrl_if.sv
// Implication valid/ready channel from the scan sequencer to the implication queue.
interface bcp_scan_ctrl_if #(
  parameter int unsigned ADDR_W = 4
) ();

  logic              impl_valid;
  logic              impl_ready;
  logic [ADDR_W-1:0] impl_clause;
  logic [1:0]        impl_slot;
  logic              impl_value;

  modport master (
    output impl_valid,
    output impl_clause,
    output impl_slot,
    output impl_value,
    input  impl_ready
  );

  modport slave (
    input  impl_valid,
    input  impl_clause,
    input  impl_slot,
    input  impl_value,
    output impl_ready
  );

endinterface

// File: rtl/bcp_onehot_enc.sv
// One-hot to slot-index encoder; the lowest set bit wins if several are set.
module bcp_onehot_enc (
  input  logic [3:0] onehot,
  output logic [1:0] slot,
  output logic       any
);

  // Priority encode from bit 0 upward.
  always_comb begin
    slot = 2'd0;
    any  = |onehot;
    if (onehot[0]) begin
      slot = 2'd0;
    end else if (onehot[1]) begin
      slot = 2'd1;
    end else if (onehot[2]) begin
      slot = 2'd2;
    end else if (onehot[3]) begin
      slot = 2'd3;
    end
  end

endmodule

// File: rtl/bcp_scan_ctrl.sv
// Clause-scan sequencer: walks the clause store, feeds the unit-clause checker
// and forwards each detected implication over a valid/ready channel.
module bcp_scan_ctrl
  import bcp_pkg::*;
#(
  parameter int unsigned NUM_CLAUSES = 16,
  parameter int unsigned ADDR_W      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 mem_rd_en,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [CLAUSE_W-1:0]  mem_rd_data,
  output logic [7:0]           chk_clause,
  output logic [7:0]           chk_clause_type,
  output logic [3:0]           chk_clause_odd,
  input  logic [LIT_SLOTS-1:0] chk_unit,
  bcp_scan_ctrl_if.master      impl,
  output logic [ADDR_W:0]      impl_count
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_CLAUSES - 1);
  localparam logic [ADDR_W-1:0] IDX_ONE  = 1;
  localparam logic [ADDR_W:0]   CNT_ONE  = 1;

  scan_state_e       state_q, state_d;
  logic [ADDR_W-1:0] index_q, index_d;
  clause_word_t      chk_word_q, chk_word_d;
  logic [ADDR_W-1:0] impl_clause_q, impl_clause_d;
  logic [1:0]        impl_slot_q, impl_slot_d;
  logic              impl_value_q, impl_value_d;
  logic [ADDR_W:0]   impl_count_q, impl_count_d;

  logic [1:0]        enc_slot;
  logic              enc_any;
  logic              advance;

  bcp_onehot_enc u_enc (
    .onehot (chk_unit),
    .slot   (enc_slot),
    .any    (enc_any)
  );

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      index_q       <= '0;
      chk_word_q    <= '0;
      impl_clause_q <= '0;
      impl_slot_q   <= '0;
      impl_value_q  <= 1'b0;
      impl_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      index_q       <= index_d;
      chk_word_q    <= chk_word_d;
      impl_clause_q <= impl_clause_d;
      impl_slot_q   <= impl_slot_d;
      impl_value_q  <= impl_value_d;
      impl_count_q  <= impl_count_d;
    end
  end

  // Next-state and datapath updates; RESULT and EMIT share the advance step.
  always_comb begin
    state_d       = state_q;
    index_d       = index_q;
    chk_word_d    = chk_word_q;
    impl_clause_d = impl_clause_q;
    impl_slot_d   = impl_slot_q;
    impl_value_d  = impl_value_q;
    impl_count_d  = impl_count_q;
    advance       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          index_d      = '0;
          impl_count_d = '0;
          state_d      = S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        chk_word_d = clause_word_t'(mem_rd_data);
        state_d    = S_EVAL;
      end
      S_EVAL: begin
        state_d = S_RESULT;
      end
      S_RESULT: begin
        if (enc_any) begin
          impl_clause_d = index_q;
          impl_slot_d   = enc_slot;
          impl_value_d  = chk_word_q.ctype[{1'b0, enc_slot}];
          state_d       = S_EMIT;
        end else begin
          advance = 1'b1;
        end
      end
      S_EMIT: begin
        if (impl.impl_ready) begin
          impl_count_d = impl_count_q + CNT_ONE;
          advance      = 1'b1;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (advance) begin
      if (index_q == LAST_IDX) begin
        state_d = S_FINISH;
      end else begin
        index_d = index_q + IDX_ONE;
        state_d = S_FETCH;
      end
    end
  end

  // Outputs are decoded straight from registered state, so reset clears them at once.
  always_comb begin
    busy             = (state_q != S_IDLE);
    done             = (state_q == S_FINISH);
    mem_rd_en        = (state_q == S_FETCH);
    mem_addr         = index_q;
    chk_clause       = chk_word_q.lits;
    chk_clause_type  = chk_word_q.ctype;
    chk_clause_odd   = chk_word_q.odd;
    impl.impl_valid  = (state_q == S_EMIT);
    impl.impl_clause = impl_clause_q;
    impl.impl_slot   = impl_slot_q;
    impl.impl_value  = impl_value_q;
    impl_count       = impl_count_q;
  end

endmodule

// File: tb/tb_bcp_scan_ctrl.sv
// Directed bench for bcp_scan_ctrl with a clause-memory model and a registered checker model.
module tb_bcp_scan_ctrl;

  logic clk, rst;
  int   total = 0;
  int   bad   = 0;

  // ---------------- main DUT (16 clauses) ----------------
  logic        start, busy, done, mem_rd_en;
  logic [3:0]  mem_addr;
  logic [19:0] mem_rd_data;
  logic [7:0]  chk_clause, chk_clause_type;
  logic [3:0]  chk_clause_odd, chk_unit;
  logic [4:0]  impl_count;
  logic [19:0] mem [16];

  bcp_scan_ctrl_if #(.ADDR_W(4)) ifc ();

  bcp_scan_ctrl #(.NUM_CLAUSES(16), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .chk_clause(chk_clause), .chk_clause_type(chk_clause_type),
    .chk_clause_odd(chk_clause_odd), .chk_unit(chk_unit),
    .impl(ifc.master), .impl_count(impl_count)
  );

  // ---------------- single-clause DUT ----------------
  logic        start1, busy1, done1, mem_rd_en1;
  logic [0:0]  mem_addr1;
  logic [19:0] mem_rd_data1;
  logic [7:0]  chk_clause1, chk_clause_type1;
  logic [3:0]  chk_clause_odd1, chk_unit1;
  logic [1:0]  impl_count1;

  bcp_scan_ctrl_if #(.ADDR_W(1)) ifc1 ();
  assign ifc1.impl_ready = 1'b1;

  bcp_scan_ctrl #(.NUM_CLAUSES(1), .ADDR_W(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
    .mem_rd_en(mem_rd_en1), .mem_addr(mem_addr1), .mem_rd_data(mem_rd_data1),
    .chk_clause(chk_clause1), .chk_clause_type(chk_clause_type1),
    .chk_clause_odd(chk_clause_odd1), .chk_unit(chk_unit1),
    .impl(ifc1.master), .impl_count(impl_count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Unit-clause checker stand-in: known clause words map to hand-derived unit vectors.
  function automatic logic [3:0] unit_of(input logic [19:0] w);
    case (w)
      20'hEC544: unit_of = 4'b0001;
      20'h14000: unit_of = 4'b0010;
      20'h24000: unit_of = 4'b0001;
      20'h3A600: unit_of = 4'b0110;
      default:   unit_of = 4'b0000;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_unit  <= '0;
      chk_unit1 <= '0;
    end else begin
      chk_unit  <= unit_of({chk_clause_odd, chk_clause_type, chk_clause});
      chk_unit1 <= unit_of({chk_clause_odd1, chk_clause_type1, chk_clause1});
    end
  end

  // Clause memories: read data is valid the cycle after the strobe.
  always_ff @(posedge clk) begin
    if (mem_rd_en)  mem_rd_data  <= mem[mem_addr];
    if (mem_rd_en1) mem_rd_data1 <= 20'hC0000;
  end

  // Monitor: handshakes, done pulses, and any valid on the single-clause DUT.
  typedef struct packed {
    logic [3:0] c;
    logic [1:0] s;
    logic       v;
  } impl_t;
  impl_t log_q[$];
  int    done_cnt = 0;
  int    valid1_cnt = 0;

  always @(negedge clk) begin
    if (!rst && ifc.impl_valid && ifc.impl_ready)
      log_q.push_back({ifc.impl_clause, ifc.impl_slot, ifc.impl_value});
    if (!rst && done) done_cnt++;
    if (!rst && ifc1.impl_valid) valid1_cnt++;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fill_mem(input int idx, input logic [19:0] w);
    for (int i = 0; i < 16; i++) mem[i] = 20'hC0000;
    mem[idx] = w;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_done_seen"}, 32'(n < 400), 1);
  endtask

  task automatic wait_valid(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!ifc.impl_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_valid_seen"}, 32'(n < 200), 1);
  endtask

  typedef struct {
    int         idx;
    logic [19:0] word;
    bit         has_impl;
    logic [3:0] clause;
    logic [1:0] slot;
    logic       value;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int    base_log, base_done, k;
    impl_t e;

    vecs[0] = '{idx: 3,  word: 20'hEC544, has_impl: 1'b1, clause: 4'd3,  slot: 2'd0, value: 1'b1};
    vecs[1] = '{idx: 0,  word: 20'h3A600, has_impl: 1'b1, clause: 4'd0,  slot: 2'd1, value: 1'b1};
    vecs[2] = '{idx: 15, word: 20'h14000, has_impl: 1'b1, clause: 4'd15, slot: 2'd1, value: 1'b0};
    vecs[3] = '{idx: 7,  word: 20'hC0000, has_impl: 1'b0, clause: 4'd0,  slot: 2'd0, value: 1'b0};
    vecs[4] = '{idx: 0,  word: 20'h24000, has_impl: 1'b1, clause: 4'd0,  slot: 2'd0, value: 1'b0};

    rst = 1'b0; start = 1'b0; start1 = 1'b0; ifc.impl_ready = 1'b1;
    fill_mem(0, 20'hC0000);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_valid", ifc.impl_valid, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_count", impl_count, 0);
    check("rst_chk", {chk_clause_odd, chk_clause_type, chk_clause}, 0);
    rst = 1'b0;

    // Single-clause pass: done arrives on the 5th edge after start is sampled.
    @(posedge clk); #1 start1 = 1'b1;
    k = 0;
    while (!done1 && k < 50) begin
      @(posedge clk); #1;
      k++;
      if (k == 1) start1 = 1'b0;
    end
    start1 = 1'b0;
    check("n1_latency", k, 5);
    @(posedge clk); #1;
    check("n1_done_len", done1, 0);
    check("n1_count", impl_count1, 0);
    check("n1_no_valid", valid1_cnt, 0);

    // Table-driven passes, one interesting clause each.
    for (int t = 0; t < 5; t++) begin
      fill_mem(vecs[t].idx, vecs[t].word);
      base_log  = log_q.size();
      base_done = done_cnt;
      pulse_start();
      wait_done($sformatf("vec%0d", t));
      @(posedge clk); #1;
      check($sformatf("vec%0d_nimpl", t), log_q.size() - base_log, vecs[t].has_impl ? 1 : 0);
      check($sformatf("vec%0d_count", t), impl_count, vecs[t].has_impl ? 1 : 0);
      check($sformatf("vec%0d_dones", t), done_cnt - base_done, 1);
      if (vecs[t].has_impl && log_q.size() > base_log) begin
        e = log_q[base_log];
        check($sformatf("vec%0d_impl", t), {e.c, e.s, e.v},
              {vecs[t].clause, vecs[t].slot, vecs[t].value});
      end
    end

    // Back-pressure: implication held stable, no fetch until the handshake.
    fill_mem(3, 20'hEC544);
    ifc.impl_ready = 1'b0;
    base_log = log_q.size();
    pulse_start();
    wait_valid("bp");
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_hold%0d", i),
            {ifc.impl_valid, ifc.impl_clause, ifc.impl_slot, ifc.impl_value, mem_rd_en},
            {1'b1, 4'd3, 2'd0, 1'b1, 1'b0});
      @(negedge clk);
    end
    @(posedge clk); #1 ifc.impl_ready = 1'b1;
    @(negedge clk);
    check("bp_valid_at_hs", ifc.impl_valid, 1);
    @(negedge clk);
    check("bp_next_fetch", {mem_rd_en, mem_addr, ifc.impl_valid}, {1'b1, 4'd4, 1'b0});
    wait_done("bp");
    @(posedge clk); #1;
    check("bp_count", impl_count, 1);
    check("bp_nimpl", log_q.size() - base_log, 1);

    // Two implications in order, with a stray start mid-scan.
    fill_mem(1, 20'h14000);
    mem[2] = 20'h24000;
    base_log  = log_q.size();
    base_done = done_cnt;
    pulse_start();
    repeat (6) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done("two");
    @(posedge clk); #1;
    check("two_nimpl", log_q.size() - base_log, 2);
    check("two_count", impl_count, 2);
    if (log_q.size() - base_log >= 2) begin
      e = log_q[base_log];
      check("two_first", {e.c, e.s, e.v}, {4'd1, 2'd1, 1'b0});
      e = log_q[base_log + 1];
      check("two_second", {e.c, e.s, e.v}, {4'd2, 2'd0, 1'b0});
    end
    repeat (8) @(negedge clk);
    check("two_dones", done_cnt - base_done, 1);
    check("two_no_restart", busy, 0);

    // Async reset while an implication is pending.
    fill_mem(1, 20'h14000);
    mem[3] = 20'hEC544;
    ifc.impl_ready = 1'b0;
    pulse_start();
    wait_valid("rst1");
    @(posedge clk); #1 ifc.impl_ready = 1'b1;
    @(posedge clk); #1 ifc.impl_ready = 1'b0;
    wait_valid("rst2");
    check("rst_pre_count", impl_count, 1);
    check("rst_pre_clause", ifc.impl_clause, 3);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", ifc.impl_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_count", impl_count, 0);
    @(posedge clk); #1 rst = 1'b0;
    ifc.impl_ready = 1'b1;
    fill_mem(0, 20'h24000);
    base_log = log_q.size();
    pulse_start();
    @(negedge clk);
    check("rescan_fetch0", {mem_rd_en, mem_addr}, {1'b1, 4'd0});
    wait_done("rescan");
    @(posedge clk); #1;
    check("rescan_nimpl", log_q.size() - base_log, 1);
    if (log_q.size() > base_log) begin
      e = log_q[base_log];
      check("rescan_impl", {e.c, e.s, e.v}, {4'd0, 2'd0, 1'b0});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
